// File: rtl/reg_file_sequencer_pkg.sv
// Shared constants for reg_file_sequencer: opcode classes, FSM state encoding,
// instruction field offsets and write-back source encodings.
package reg_file_sequencer_pkg;

    localparam int OPC_W  = 16;
    localparam int ADDR_W = 4;

    // Instruction layout: [31:16] opcode, [11:8] addr_1, [7:4] addr_2, [3:0] addr_3.
    localparam int INSTR_OPC_LSB   = 16;
    localparam int INSTR_ADDR1_LSB = 8;
    localparam int INSTR_ADDR2_LSB = 4;
    localparam int INSTR_ADDR3_LSB = 0;

    localparam logic [3:0] OPC_ALU_NIB   = 4'h1;
    localparam logic [7:0] OPC_READ      = 8'h22;
    localparam logic [7:0] OPC_READ_RAM  = 8'h92;
    localparam logic [7:0] OPC_WRITE_RAM = 8'h91;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ISSUE    = 3'd1;
    localparam state_t ST_ALU_WAIT = 3'd2;
    localparam state_t ST_RAM_WAIT = 3'd3;
    localparam state_t ST_WB       = 3'd4;
    localparam state_t ST_RDOUT    = 3'd5;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_RAM = 1'b1;

endpackage

// File: rtl/reg_file_sequencer_seq_op_decode.sv
// Combinational opcode-to-class decoder; exactly one class output is high
// for any opcode, with is_illegal covering everything undecodable.
module seq_op_decode
    import reg_file_sequencer_pkg::*;
(
    input  logic [OPC_W-1:0] op,
    output logic             is_alu,
    output logic             is_read,
    output logic             is_ram_rd,
    output logic             is_ram_wr,
    output logic             is_illegal
);

    // Only the upper byte carries class information.
    logic unused_op_low;
    assign unused_op_low = ^op[7:0];

    always_comb begin
        is_alu     = (op[15:12] == OPC_ALU_NIB);
        is_read    = (op[15:8] == OPC_READ);
        is_ram_rd  = (op[15:8] == OPC_READ_RAM);
        is_ram_wr  = (op[15:8] == OPC_WRITE_RAM);
        is_illegal = !(is_alu || is_read || is_ram_rd || is_ram_wr);
    end

endmodule

// File: rtl/reg_file_sequencer.sv
// Register-file sequencer FSM: one instruction at a time through ISSUE, an
// ALU/RAM wait, write-back or read-out. Define SEQ_TIMEOUT_EN for a wait watchdog.
module reg_file_sequencer
    import reg_file_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16
`ifdef SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic [OPC_W-1:0]      opcode,
    output logic [ADDR_W-1:0]     addr_1,
    output logic [ADDR_W-1:0]     addr_2,
    output logic [ADDR_W-1:0]     addr_3,
    output logic                  write_enable,
    output logic                  wb_src,
    output logic                  alu_start,
    input  logic                  alu_done,
    output logic                  ram_req,
    output logic                  ram_we,
    input  logic                  ram_ack,
    input  logic [DATA_WIDTH-1:0] read_data_reg,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  illegal_op,
    output logic                  busy,
    output logic [2:0]            state_dbg
`ifdef SEQ_TIMEOUT_EN
    , output logic                timeout_err
`endif
);

    // Handshake: an instruction transfers on a rising edge where
    // instr_valid && instr_ready; instr_ready is high only in IDLE.
    state_t                  state_q, state_d;
    logic [OPC_W-1:0]        opcode_q, opcode_d, dec_op;
    logic [ADDR_W-1:0]       addr_1_q, addr_1_d, addr_2_q, addr_2_d, addr_3_q, addr_3_d;
    logic                    write_enable_q, write_enable_d;
    logic                    wb_src_q, wb_src_d;
    logic                    alu_start_q, alu_start_d;
    logic                    ram_req_q, ram_req_d;
    logic                    ram_we_q, ram_we_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    illegal_op_q, illegal_op_d;
    logic                    instr_ready_q, instr_ready_d;
    logic                    busy_q, busy_d;
    logic                    accept;
    logic                    is_alu, is_read, is_ram_rd, is_ram_wr, is_illegal;
    logic                    unused_instr_gap;

    assign unused_instr_gap = ^instr[15:12];
    assign accept           = instr_valid && instr_ready_q;

    // In IDLE the decoder looks at the incoming word so the ISSUE-cycle
    // strobes can be registered at the accept edge.
    assign dec_op = (state_q == ST_IDLE) ? instr[INSTR_OPC_LSB +: OPC_W] : opcode_q;

    seq_op_decode u_dec (
        .op         (dec_op),
        .is_alu     (is_alu),
        .is_read    (is_read),
        .is_ram_rd  (is_ram_rd),
        .is_ram_wr  (is_ram_wr),
        .is_illegal (is_illegal)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_err_q, timeout_err_d;
    logic       wait_expired;
    assign wait_expired = (wait_cnt_q == WAIT_LAST);
`endif

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        addr_1_d       = addr_1_q;
        addr_2_d       = addr_2_q;
        addr_3_d       = addr_3_q;
        write_enable_d = 1'b0;
        wb_src_d       = wb_src_q;
        alu_start_d    = 1'b0;
        ram_req_d      = ram_req_q;
        ram_we_d       = ram_we_q;
        rd_data_d      = rd_data_q;
        rd_valid_d     = 1'b0;
        illegal_op_d   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
        timeout_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_ISSUE;
                    opcode_d     = instr[INSTR_OPC_LSB +: OPC_W];
                    addr_1_d     = instr[INSTR_ADDR1_LSB +: ADDR_W];
                    addr_2_d     = instr[INSTR_ADDR2_LSB +: ADDR_W];
                    addr_3_d     = instr[INSTR_ADDR3_LSB +: ADDR_W];
                    alu_start_d  = is_alu;
                    ram_req_d    = is_ram_rd || is_ram_wr;
                    ram_we_d     = is_ram_wr;
                    illegal_op_d = is_illegal;
                end
            end
            ST_ISSUE: begin
`ifdef SEQ_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                if (is_alu) begin
                    state_d = ST_ALU_WAIT;
                end else if (is_ram_rd || is_ram_wr) begin
                    state_d = ST_RAM_WAIT;
                end else if (is_read) begin
                    state_d = ST_RDOUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALU_WAIT: begin
                if (alu_done) begin
                    wb_src_d       = WB_SRC_ALU;
                    write_enable_d = 1'b1;
                    state_d        = ST_WB;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wait_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            ST_RAM_WAIT: begin
                if (ram_ack) begin
                    ram_req_d = 1'b0;
                    ram_we_d  = 1'b0;
                    if (is_ram_rd) begin
                        wb_src_d       = WB_SRC_RAM;
                        write_enable_d = 1'b1;
                        state_d        = ST_WB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wait_expired) begin
                    ram_req_d     = 1'b0;
                    ram_we_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            ST_RDOUT: begin
                rd_data_d  = read_data_reg;
                rd_valid_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Leaving an instruction parks the register-file buses at zero.
        if (state_d == ST_IDLE) begin
            opcode_d = '0;
            addr_1_d = '0;
            addr_2_d = '0;
            addr_3_d = '0;
        end
        instr_ready_d = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            opcode_q       <= '0;
            addr_1_q       <= '0;
            addr_2_q       <= '0;
            addr_3_q       <= '0;
            write_enable_q <= 1'b0;
            wb_src_q       <= WB_SRC_ALU;
            alu_start_q    <= 1'b0;
            ram_req_q      <= 1'b0;
            ram_we_q       <= 1'b0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            illegal_op_q   <= 1'b0;
            instr_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            addr_1_q       <= addr_1_d;
            addr_2_q       <= addr_2_d;
            addr_3_q       <= addr_3_d;
            write_enable_q <= write_enable_d;
            wb_src_q       <= wb_src_d;
            alu_start_q    <= alu_start_d;
            ram_req_q      <= ram_req_d;
            ram_we_q       <= ram_we_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            illegal_op_q   <= illegal_op_d;
            instr_ready_q  <= instr_ready_d;
            busy_q         <= busy_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`endif

    assign instr_ready  = instr_ready_q;
    assign opcode       = opcode_q;
    assign addr_1       = addr_1_q;
    assign addr_2       = addr_2_q;
    assign addr_3       = addr_3_q;
    assign write_enable = write_enable_q;
    assign wb_src       = wb_src_q;
    assign alu_start    = alu_start_q;
    assign ram_req      = ram_req_q;
    assign ram_we       = ram_we_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign illegal_op   = illegal_op_q;
    assign busy         = busy_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Self-checking bench for reg_file_sequencer: directed and random instructions,
// event scoreboard, latency checks and a mid-instruction reset abort.
module tb_reg_file_sequencer;

    localparam int DW = 16;
    localparam int EW = 36;
    localparam logic [3:0] K_ALU = 4'd1;
    localparam logic [3:0] K_WE  = 4'd2;
    localparam logic [3:0] K_RD  = 4'd3;
    localparam logic [3:0] K_REQ = 4'd4;
    localparam logic [3:0] K_ILL = 4'd5;
`ifdef SEQ_TIMEOUT_EN
    localparam int TO     = 4;
    localparam int TO_LAT = TO + 2;
`else
    localparam int TO_LAT = 0;
`endif

    // ---------------- clock / reset / signals ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid, instr_ready;
    logic [31:0]   instr;
    logic [15:0]   opcode;
    logic [3:0]    addr_1, addr_2, addr_3;
    logic          write_enable, wb_src, alu_start, alu_done;
    logic          ram_req, ram_we, ram_ack;
    logic [DW-1:0] read_data_reg, rd_data;
    logic          rd_valid, illegal_op, busy;
    logic [2:0]    state_dbg;
`ifdef SEQ_TIMEOUT_EN
    logic          timeout_err;
`endif
    logic [55:0]   outs;
    logic          prev_req;

    logic [EW-1:0] exp_q[$];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    assign outs = {instr_ready, opcode, addr_1, addr_2, addr_3, write_enable, wb_src,
                   alu_start, ram_req, ram_we, rd_data, rd_valid, illegal_op, busy, state_dbg};

    reg_file_sequencer #(
        .DATA_WIDTH     (DW)
`ifdef SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .opcode        (opcode),
        .addr_1        (addr_1),
        .addr_2        (addr_2),
        .addr_3        (addr_3),
        .write_enable  (write_enable),
        .wb_src        (wb_src),
        .alu_start     (alu_start),
        .alu_done      (alu_done),
        .ram_req       (ram_req),
        .ram_we        (ram_we),
        .ram_ack       (ram_ack),
        .read_data_reg (read_data_reg),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .illegal_op    (illegal_op),
        .busy          (busy),
        .state_dbg     (state_dbg)
`ifdef SEQ_TIMEOUT_EN
        , .timeout_err (timeout_err)
`endif
    );

    // ---------------- checking / scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [EW-1:0] ev);
        if (exp_q.size() == 0) check({tag, "_unexpected"}, 64'(ev), 64'd0);
        else check(tag, 64'(ev), 64'(exp_q.pop_front()));
    endtask

    function automatic int op_class(input logic [15:0] op);
        if (op[15:12] == 4'h1) return 1;
        if (op[15:8] == 8'h22) return 2;
        if (op[15:8] == 8'h92) return 3;
        if (op[15:8] == 8'h91) return 4;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (alu_start)           sb_pop("alu_start", {K_ALU, opcode, addr_1, addr_2, addr_3, 4'h0});
            if (ram_req && !prev_req) sb_pop("ram_req", {K_REQ, opcode, 8'h0, 3'b0, ram_we, addr_3});
            if (write_enable)        sb_pop("write_enable", {K_WE, opcode, 8'h0, 3'b0, wb_src, addr_3});
            if (rd_valid)            sb_pop("rd_valid", {K_RD, 16'h0, rd_data});
            if (illegal_op)          sb_pop("illegal_op", {K_ILL, opcode, 16'h0});
            check("busy", 64'(busy), 64'(!instr_ready));
            prev_req <= ram_req;
        end else begin
            prev_req <= 1'b0;
        end
    end

    // ---------------- driver ----------------
    // done_cyc: cycle after accept in which alu_done/ram_ack is driven (0 = never).
    task automatic run_instr(input logic [31:0] w, input int done_cyc, input bit early,
                             input logic [15:0] rdv);
        logic [15:0] op;
        logic [3:0]  a1, a2, a3;
        int          cls, exp_lat, c;
        op = w[31:16]; a1 = w[11:8]; a2 = w[7:4]; a3 = w[3:0];
        cls = op_class(op);
        c = 0;
        while (!instr_ready && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (!instr_ready) begin
            check("ready_wait", 64'(instr_ready), 64'd1);
            return;
        end
        case (cls)
            1: begin
                exp_q.push_back({K_ALU, op, a1, a2, a3, 4'h0});
                exp_q.push_back({K_WE, op, 8'h0, 3'b0, 1'b0, a3});
                exp_lat = done_cyc + 2;
            end
            2: begin
                exp_q.push_back({K_RD, 16'h0, rdv});
                exp_lat = 3;
            end
            3, 4: begin
                exp_q.push_back({K_REQ, op, 8'h0, 3'b0, (cls == 4), a3});
                if (done_cyc == 0) exp_lat = TO_LAT;
                else if (cls == 3) begin
                    exp_q.push_back({K_WE, op, 8'h0, 3'b0, 1'b1, a3});
                    exp_lat = done_cyc + 2;
                end else exp_lat = done_cyc + 1;
            end
            default: begin
                exp_q.push_back({K_ILL, op, 16'h0});
                exp_lat = 2;
            end
        endcase
        instr = w; instr_valid = 1'b1; read_data_reg = rdv;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = $urandom;
        for (c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (instr_ready) break;
            alu_done = (cls == 1) && ((c == done_cyc) || (early && c == 1));
            ram_ack  = (cls == 3 || cls == 4) && (c == done_cyc);
        end
        alu_done = 1'b0;
        ram_ack  = 1'b0;
        check("latency", 64'(c), 64'(exp_lat));
        check("idle_bus", 64'({opcode, addr_1, addr_2, addr_3}), 64'd0);
`ifdef SEQ_TIMEOUT_EN
        check("timeout_err", 64'(timeout_err), 64'(done_cyc == 0 && (cls == 3 || cls == 4)));
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rop;
        logic [31:0] rw;
        int          k;
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        alu_done = 1'b0; ram_ack = 1'b0; read_data_reg = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", 64'(outs), 64'({1'b1, 55'b0}));
        reset = 1'b0;
        @(negedge clk);

        run_instr(32'h1000_0123, 3, 1'b0, 16'h0);
        run_instr(32'h1F00_0A5C, 4, 1'b1, 16'h0);
        run_instr(32'h9200_0005, 5, 1'b0, 16'h0);
        run_instr(32'h9100_0007, 2, 1'b0, 16'h0);
        run_instr(32'h2200_0004, 2, 1'b0, 16'hBEEF);
        run_instr(32'h5500_0000, 2, 1'b0, 16'h0);

        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 4);
            case (k)
                0:       rop = {4'h1, 12'($urandom)};
                1:       rop = {8'h22, 8'($urandom)};
                2:       rop = {8'h92, 8'($urandom)};
                3:       rop = {8'h91, 8'($urandom)};
                default: rop = 16'($urandom);
            endcase
            rw = {rop, 4'($urandom), 12'($urandom)};
            run_instr(rw, $urandom_range(2, 6), 1'($urandom), 16'($urandom));
        end

`ifdef SEQ_TIMEOUT_EN
        run_instr(32'h9200_0003, 0, 1'b0, 16'h0);
        run_instr(32'h9100_0002, 0, 1'b0, 16'h0);
`endif

        // Reset while waiting on the ALU, then a stale alu_done.
        instr = 32'h1ABC_0456; instr_valid = 1'b1;
        exp_q.push_back({K_ALU, 16'h1ABC, 4'h4, 4'h5, 4'h6, 4'h0});
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("alu_wait_state", 64'(state_dbg), 64'd2);
        #1;
        reset = 1'b1;
        #1;
        check("abort_outs", 64'(outs), 64'({1'b1, 55'b0}));
        @(negedge clk);
        reset = 1'b0;
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle", 64'({instr_ready, state_dbg, opcode, write_enable}), 64'({1'b1, 20'b0}));

        check("leftover", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
